// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift arbiter: data/amount widths,
// direction encodings and the request payload carried through the pipeline.
package shift_arb_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic              dir;
    logic              arith;
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
  } shift_req_t;

endpackage

// File: rtl/shift_core.sv
// Purely combinational 32-bit barrel shifter. Left shifts reuse the right
// shifter by bit-reversing the operand on the way in and the result on the way out.
module shift_core
  import shift_arb_pkg::*;
(
  input  shift_req_t        req,
  output logic [DATA_W-1:0] result
);

  logic              fill;
  logic [DATA_W-1:0] data_rev;
  logic [DATA_W-1:0] work;
  logic [DATA_W-1:0] work_rev;

  assign fill     = (req.dir == DIR_RIGHT) & req.arith & req.data[DATA_W-1];
  assign data_rev = {<<{req.data}};
  assign work_rev = {<<{work}};

  // Five log stages; fill is only ever set for arithmetic right shifts.
  always_comb begin
    work = (req.dir == DIR_RIGHT) ? req.data : data_rev;
    if (req.amt[0]) work = {{1{fill}},  work[DATA_W-1:1]};
    if (req.amt[1]) work = {{2{fill}},  work[DATA_W-1:2]};
    if (req.amt[2]) work = {{4{fill}},  work[DATA_W-1:4]};
    if (req.amt[3]) work = {{8{fill}},  work[DATA_W-1:8]};
    if (req.amt[4]) work = {{16{fill}}, work[DATA_W-1:16]};
  end

  assign result = (req.dir == DIR_RIGHT) ? work : work_rev;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between NREQ requesters through a
// two-stage pipeline. Define SHIFT_ARB_PRIORITY_EN to give requester 0 absolute priority.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_dir,
  input  logic [NREQ-1:0]        req_arith,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ*AMT_W-1:0]  req_amt,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [DATA_W-1:0]      resp_data
);

  // Handshake: a transfer happens on a rising clk edge where valid and ready
  // are both high. Requesters hold valid and payload stable until that edge;
  // req_ready is combinational and may depend on req_valid. The response
  // channel follows the same rule, with resp_id/resp_data frozen while stalled.

  logic              a_valid;
  shift_req_t        a_req;
  logic [IDW-1:0]    a_id;
  logic [IDW-1:0]    rr_ptr;

  logic              adv_a;
  logic              adv_b;
  logic              grant_found;
  logic [IDW-1:0]    grant_id;
  logic              ptr_update;
  logic [IDW-1:0]    rr_next;
  logic              xfer;
  shift_req_t        grant_req;
  logic [DATA_W-1:0] shift_out;

  // First set bit of valid at or after ptr, wrapping at NREQ-1; MSB = found.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IDW'((int'(ptr) + off) % NREQ);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign adv_b = !resp_valid || resp_ready;
  assign adv_a = !a_valid || adv_b;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    ptr_update  = 1'b0;
`ifdef SHIFT_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      grant_found = 1'b1;
      grant_id    = '0;
      ptr_update  = 1'b0;
    end else begin
      {grant_found, grant_id} = rr_pick(req_valid & ~NREQ'(1), rr_ptr);
      ptr_update              = grant_found;
    end
`else
    {grant_found, grant_id} = rr_pick(req_valid, rr_ptr);
    ptr_update              = grant_found;
`endif
  end

  assign req_ready = (!reset && adv_a && grant_found) ? (NREQ'(1) << grant_id) : '0;
  assign xfer      = |(req_valid & req_ready);
  assign rr_next   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    grant_req.dir   = req_dir[grant_id];
    grant_req.arith = req_arith[grant_id];
    grant_req.data  = req_data[DATA_W*grant_id +: DATA_W];
    grant_req.amt   = req_amt[AMT_W*grant_id +: AMT_W];
  end

  shift_core u_shift_core (
    .req    (a_req),
    .result (shift_out)
  );

  // Stage A: operand register, refilled whenever it can advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_req   <= '0;
      a_id    <= '0;
      rr_ptr  <= '0;
    end else begin
      if (adv_a) begin
        a_valid <= xfer;
        if (xfer) begin
          a_req <= grant_req;
          a_id  <= grant_id;
        end
      end
      if (xfer && ptr_update) begin
        rr_ptr <= rr_next;
      end
    end
  end

  // Stage B: result register, frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else if (adv_b) begin
      resp_valid <= a_valid;
      if (a_valid) begin
        resp_id   <= a_id;
        resp_data <= shift_out;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_shift_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_dir;
  logic [NREQ-1:0]      req_arith;
  logic [NREQ*32-1:0]   req_data;
  logic [NREQ*5-1:0]    req_amt;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [31:0]          resp_data;

  always #5 clk = ~clk;

  shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dir    (req_dir),
    .req_arith  (req_arith),
    .req_data   (req_data),
    .req_amt    (req_amt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // requester-side pending requests
  bit          p_valid [NREQ];
  bit          p_dir   [NREQ];
  bit          p_arith [NREQ];
  logic [31:0] p_data  [NREQ];
  logic [4:0]  p_amt   [NREQ];

  // reference model: in-flight results in acceptance order
  logic [31:0] exp_q     [$];
  int          exp_id_q  [$];
  int          exp_cyc_q [$];
  int          m_ptr = 0;
  int          cyc   = 0;

  int          dut_grant_log [$];
  int          resp_log      [$];
  logic [31:0] last_data;
  int          last_id;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic [31:0] prev_id;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_shift(input bit dir, input bit arith,
                                            input logic [31:0] d, input logic [4:0] a);
    if (!dir) return d << a;
    if (arith) return 32'($signed(d) >>> a);
    return d >> a;
  endfunction

  function automatic int ref_pick();
    int idx;
`ifdef SHIFT_ARB_PRIORITY_EN
    if (p_valid[0]) return 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (m_ptr + off) % NREQ;
      if (idx != 0 && p_valid[idx]) return idx;
    end
`else
    for (int off = 0; off < NREQ; off++) begin
      idx = (m_ptr + off) % NREQ;
      if (p_valid[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic set_req(input int i, input bit dir, input bit arith,
                         input logic [31:0] data, input logic [4:0] amt);
    p_valid[i] = 1'b1;
    p_dir[i]   = dir;
    p_arith[i] = arith;
    p_data[i]  = data;
    p_amt[i]   = amt;
  endtask

  task automatic rand_req(input int i);
    int r;
    logic [4:0] amt;
    r   = $urandom_range(0, 9);
    amt = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(0, 31));
    set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), amt);
  endtask

  // one clock cycle: drive, then check outputs and advance the model
  task automatic step(input bit rst, input bit rdy);
    int          g;
    logic [31:0] exp_ready;
    bit          exp_rv;
    @(posedge clk);
    #1;
    reset      = rst;
    resp_ready = rdy;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = p_valid[i];
      req_dir[i]           = p_dir[i];
      req_arith[i]         = p_arith[i];
      req_data[32*i +: 32] = p_data[i];
      req_amt[5*i +: 5]    = p_amt[i];
    end
    @(negedge clk);
    g = -1;
    if (!rst && (exp_q.size() < 2 || rdy)) g = ref_pick();
    exp_ready = (g >= 0) ? (32'd1 << g) : 32'd0;
    check("req_ready", 32'(req_ready), exp_ready);
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) dut_grant_log.push_back(i);
    exp_rv = (exp_q.size() > 0) && (exp_cyc_q[0] + 2 <= cyc);
    check("resp_valid", 32'(resp_valid), 32'(exp_rv));
    if (stall_prev) begin
      check("hold_data", resp_data, prev_data);
      check("hold_id", 32'(resp_id), prev_id);
    end
    stall_prev = resp_valid && !rdy && !rst;
    prev_data  = resp_data;
    prev_id    = 32'(resp_id);
    if (!rst && resp_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check("resp_extra", 32'd1, 32'd0);
      end else begin
        check("resp_data", resp_data, exp_q[0]);
        check("resp_id", 32'(resp_id), 32'(exp_id_q[0]));
        void'(exp_q.pop_front());
        void'(exp_id_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      last_data = resp_data;
      last_id   = int'(resp_id);
      resp_log.push_back(int'(resp_id));
    end
    if (g >= 0) begin
      exp_q.push_back(ref_shift(p_dir[g], p_arith[g], p_data[g], p_amt[g]));
      exp_id_q.push_back(g);
      exp_cyc_q.push_back(cyc);
      p_valid[g] = 1'b0;
`ifdef SHIFT_ARB_PRIORITY_EN
      if (g != 0) m_ptr = (g + 1) % NREQ;
`else
      m_ptr = (g + 1) % NREQ;
`endif
    end
    if (rst) begin
      exp_q.delete();
      exp_id_q.delete();
      exp_cyc_q.delete();
      m_ptr      = 0;
      stall_prev = 1'b0;
    end
    cyc++;
  endtask

  task automatic send_check(input string tag, input int id, input bit dir, input bit arith,
                            input logic [31:0] data, input logic [4:0] amt,
                            input logic [31:0] exp_data);
    int n0;
    n0 = resp_log.size();
    last_data = 32'hDEAD_BEEF;
    set_req(id, dir, arith, data, amt);
    repeat (4) step(1'b0, 1'b1);
    check({tag, "_count"}, 32'(resp_log.size() - n0), 32'd1);
    check(tag, last_data, exp_data);
    check({tag, "_id"}, 32'(last_id), 32'(id));
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 32'd0, 5'd0);
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    reset      = 1'b1;
    resp_ready = 1'b0;
    req_valid  = '0;
    req_dir    = '0;
    req_arith  = '0;
    req_data   = '0;
    req_amt    = '0;
    repeat (3) @(posedge clk);

    // reset values
    step(1'b0, 1'b1);
    check("reset_id", 32'(resp_id), 32'd0);
    check("reset_data", resp_data, 32'd0);

    // single requests covering each shift mode
    send_check("sra4", 0, 1'b1, 1'b1, 32'h8000_0010, 5'd4, 32'hF800_0001);
    send_check("srl4", 0, 1'b1, 1'b0, 32'h8000_0010, 5'd4, 32'h0800_0001);
    send_check("sll31", 0, 1'b0, 1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000);
    send_check("amt0", 0, 1'b1, 1'b1, 32'h8765_4321, 5'd0, 32'h8765_4321);

    // all requesters continuously valid, from a fresh pointer
    step(1'b1, 1'b1);
    dut_grant_log.delete();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) if (!p_valid[i]) rand_req(i);
      step(1'b0, 1'b1);
    end
    check("rr_count", 32'(dut_grant_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < dut_grant_log.size(); k++)
`ifdef SHIFT_ARB_PRIORITY_EN
      check("prio_order", 32'(dut_grant_log[k]), 32'd0);
`else
      check("rr_order", 32'(dut_grant_log[k]), 32'(k % NREQ));
`endif
`ifdef SHIFT_ARB_PRIORITY_EN
    p_valid[0] = 1'b0;
    dut_grant_log.delete();
    for (int c = 0; c < 6; c++) begin
      for (int i = 1; i < NREQ; i++) if (!p_valid[i]) rand_req(i);
      step(1'b0, 1'b1);
    end
    check("prio_rr_count", 32'(dut_grant_log.size()), 32'd6);
    for (int k = 0; k < 6 && k < dut_grant_log.size(); k++)
      check("prio_rr_order", 32'(dut_grant_log[k]), 32'(1 + (k % 3)));
`endif
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    repeat (3) step(1'b0, 1'b1);

    // backpressure with both stages full and a third requester waiting
    resp_log.delete();
    rand_req(1);
    rand_req(2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    rand_req(3);
    repeat (5) step(1'b0, 1'b0);
    check("bp_ready", 32'(req_ready), 32'd0);
    check("bp_no_resp", 32'(resp_log.size()), 32'd0);
    repeat (5) step(1'b0, 1'b1);
    check("bp_drained", 32'(resp_log.size()), 32'd3);
    check("bp_empty", 32'(exp_q.size()), 32'd0);

    // reset with both stages occupied
    rand_req(0);
    rand_req(1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    step(1'b0, 1'b1);
    check("post_reset_valid", 32'(resp_valid), 32'd0);
    send_check("post_reset_req2", 2, 1'b0, 1'b0, 32'h0000_00F0, 5'd4, 32'h0000_0F00);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!p_valid[i] && $urandom_range(0, 99) < 40) rand_req(i);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 70));
    end
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    repeat (5) step(1'b0, 1'b1);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
